// File: rtl/occ_rx_link_monitor.sv
// ----------------------------------------------------------------------------
// occ_rx_link_monitor
//
// Receive-side link supervisor for one OCC PHY lane, clocked by the PHY
// rx_clk. It requests comma realignment from the PHY, qualifies the incoming
// word stream against the far-end IDLE pattern, declares link-up, strips
// IDLE words and forwards payload words while the link is up. Error words
// and issued resyncs are counted for diagnostics.
//
// Ports:
//   clk_i         PHY rx_clk, all logic on the rising edge
//   rst_n_i       asynchronous reset, active-low
//   rx_rdy_i      PHY RX ready
//   rx_data_i     received data word (16 bits)
//   rx_k_i        received K flags (2 bits)
//   rx_enc_err_i  8b10b disparity / not-in-table error
//   rx_buf_err_i  elastic buffer over/underflow
//   rx_synced_i   PHY comma alignment done
//   rx_resync_o   realignment request to the PHY (high throughout RESYNC)
//   link_up_o     link qualified (high throughout LOCKED)
//   data_o        forwarded payload word, one cycle after capture
//   k_o           forwarded K flags
//   valid_o       qualifier for data_o / k_o
//   err_cnt_o     total error words, saturating at 16'hFFFF
//   resync_cnt_o  resyncs issued, saturating at 255
// ----------------------------------------------------------------------------
module occ_rx_link_monitor #(
    parameter logic [15:0] g_IDLE          = 16'h95bc,
    parameter logic [1:0]  g_IDLE_K        = 2'b01,
    parameter int unsigned g_ACQ_COUNT     = 8,
    parameter int unsigned g_ERR_THRESHOLD = 4,
    parameter int unsigned g_ERR_WINDOW    = 64,
    parameter int unsigned g_RESYNC_LEN    = 4,
    parameter int unsigned g_ALIGN_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_rdy_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic        rx_enc_err_i,
    input  logic        rx_buf_err_i,
    input  logic        rx_synced_i,
    output logic        rx_resync_o,
    output logic        link_up_o,
    output logic [15:0] data_o,
    output logic [1:0]  k_o,
    output logic        valid_o,
    output logic [15:0] err_cnt_o,
    output logic [7:0]  resync_cnt_o
);

    typedef enum logic [2:0] {
        ST_WAIT_RDY,
        ST_RESYNC,
        ST_WAIT_ALIGN,
        ST_ACQUIRE,
        ST_LOCKED
    } state_e;

    localparam logic [15:0] RESYNC_LAST = 16'(g_RESYNC_LEN - 1);
    localparam logic [15:0] ALIGN_LAST  = 16'(g_ALIGN_TIMEOUT - 1);
    localparam logic [15:0] WIN_LAST    = 16'(g_ERR_WINDOW - 1);
    localparam logic [7:0]  ACQ_LAST    = 8'(g_ACQ_COUNT - 1);
    localparam logic [7:0]  ERR_THR     = 8'(g_ERR_THRESHOLD);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;        // shared by RESYNC length and align timeout
    logic [7:0]  acq_q, acq_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [7:0]  win_err_q, win_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [7:0]  resync_cnt_q, resync_cnt_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  k_q, k_d;
    logic        valid_q, valid_d;

    // ------------------------------------------------------------------
    // Word classification
    // ------------------------------------------------------------------
    logic idle_pat;
    logic word_err;
    logic word_idle;
    logic [7:0] win_err_inc;
    logic threshold_hit;
    logic acq_done;

    assign idle_pat  = (rx_data_i == g_IDLE) && (rx_k_i == g_IDLE_K);
    // Any K-flagged word other than the exact IDLE is treated as corrupt.
    assign word_err  = rx_enc_err_i | rx_buf_err_i | ((rx_k_i != 2'b00) && !idle_pat);
    assign word_idle = !word_err && idle_pat;

    // On the wrap cycle the old window is discarded, so an error there
    // starts the new window at 1.
    assign win_err_inc   = (win_cnt_q == WIN_LAST) ? {7'd0, word_err}
                                                   : win_err_q + {7'd0, word_err};
    assign threshold_hit = (win_err_inc >= ERR_THR);
    assign acq_done      = word_idle && (acq_q == ACQ_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_WAIT_RDY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (rx_rdy loss > sync loss > threshold > acquire)
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first; a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        if (!rx_rdy_i) begin
            state_d = ST_WAIT_RDY;
        end else begin
            case (state_q)
                ST_WAIT_RDY:   state_d = ST_RESYNC;
                ST_RESYNC:     if (timer_q == RESYNC_LAST) state_d = ST_WAIT_ALIGN;
                ST_WAIT_ALIGN: begin
                    if (rx_synced_i)                state_d = ST_ACQUIRE;
                    else if (timer_q == ALIGN_LAST) state_d = ST_RESYNC;
                end
                ST_ACQUIRE: begin
                    if (!rx_synced_i)  state_d = ST_RESYNC;
                    else if (acq_done) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (!rx_synced_i || threshold_hit) state_d = ST_RESYNC;
                end
                default:       state_d = ST_WAIT_RDY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        rx_resync_o = (state_q == ST_RESYNC);
        link_up_o   = (state_q == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    logic stay;
    assign stay = (state_d == state_q);

    always_comb begin
        timer_d      = 16'd0;
        acq_d        = 8'd0;
        win_cnt_d    = 16'd0;
        win_err_d    = 8'd0;
        err_cnt_d    = err_cnt_q;
        resync_cnt_d = resync_cnt_q;

        // Timer restarts from 0 on every state change.
        if (stay && (state_q == ST_RESYNC || state_q == ST_WAIT_ALIGN)) begin
            timer_d = timer_q + 16'd1;
        end

        // Any non-idle word (error or plain data) restarts acquisition.
        if (stay && state_q == ST_ACQUIRE && word_idle) begin
            acq_d = acq_q + 8'd1;
        end

        if (stay && state_q == ST_LOCKED) begin
            win_cnt_d = (win_cnt_q == WIN_LAST) ? 16'd0 : win_cnt_q + 16'd1;
            win_err_d = win_err_inc;
        end

        if (rx_rdy_i && state_q != ST_WAIT_RDY && word_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        if (state_d == ST_RESYNC && state_q != ST_RESYNC && resync_cnt_q != 8'hFF) begin
            resync_cnt_d = resync_cnt_q + 8'd1;
        end
    end

    // Forwarding: the word on which LOCKED is left is dropped.
    always_comb begin
        data_d  = rx_data_i;
        k_d     = rx_k_i;
        valid_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED) && !word_err && !word_idle;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q      <= 16'd0;
            acq_q        <= 8'd0;
            win_cnt_q    <= 16'd0;
            win_err_q    <= 8'd0;
            err_cnt_q    <= 16'd0;
            resync_cnt_q <= 8'd0;
            data_q       <= 16'd0;
            k_q          <= 2'b00;
            valid_q      <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            acq_q        <= acq_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            err_cnt_q    <= err_cnt_d;
            resync_cnt_q <= resync_cnt_d;
            data_q       <= data_d;
            k_q          <= k_d;
            valid_q      <= valid_d;
        end
    end

    assign data_o       = data_q;
    assign k_o          = k_q;
    assign valid_o      = valid_q;
    assign err_cnt_o    = err_cnt_q;
    assign resync_cnt_o = resync_cnt_q;

endmodule

// File: tb/tb_occ_rx_link_monitor.sv
// ----------------------------------------------------------------------------
// tb_occ_rx_link_monitor
//
// Directed bench for occ_rx_link_monitor. Forwarded payload words are pushed
// to a scoreboard queue when driven and popped whenever valid_o is seen.
// A second instance with short resync/align timing exercises resync_cnt_o
// saturation within a small cycle budget.
// ----------------------------------------------------------------------------
module tb_occ_rx_link_monitor;

    localparam logic [15:0] IDLE   = 16'h95bc;
    localparam logic [1:0]  IDLE_K = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [15:0] rx_data;
    logic [1:0]  rx_k;
    logic        rx_enc_err;
    logic        rx_buf_err;
    logic        rx_synced;
    logic        rx_resync;
    logic        link_up;
    logic [15:0] data_o;
    logic [1:0]  k_o;
    logic        valid_o;
    logic [15:0] err_cnt;
    logic [7:0]  resync_cnt;

    logic        sat_rdy;
    logic        sat_synced;
    logic        sat_resync;
    logic        sat_link;
    logic [15:0] sat_data;
    logic [1:0]  sat_k;
    logic        sat_valid;
    logic [15:0] sat_err_cnt;
    logic [7:0]  sat_resync_cnt;

    int total = 0;
    int bad   = 0;
    int lpos  = 0;   // cycles since LOCKED entry; window position = lpos % 64
    logic [17:0] sb_q[$];

    logic [15:0] t3_data [12] = '{16'h1234, 16'h95bc, 16'h1234, 16'h1234, 16'h95bc, 16'h95bc,
                                  16'habcd, 16'h95bc, 16'h95bc, 16'h0000, 16'h1234, 16'h95bc};
    logic [1:0]  t3_k    [12] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01,
                                  2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};

    always #5 clk = ~clk;

    occ_rx_link_monitor dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rx_rdy_i     (rx_rdy),
        .rx_data_i    (rx_data),
        .rx_k_i       (rx_k),
        .rx_enc_err_i (rx_enc_err),
        .rx_buf_err_i (rx_buf_err),
        .rx_synced_i  (rx_synced),
        .rx_resync_o  (rx_resync),
        .link_up_o    (link_up),
        .data_o       (data_o),
        .k_o          (k_o),
        .valid_o      (valid_o),
        .err_cnt_o    (err_cnt),
        .resync_cnt_o (resync_cnt)
    );

    occ_rx_link_monitor #(
        .g_RESYNC_LEN    (1),
        .g_ALIGN_TIMEOUT (2)
    ) dut_sat (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rx_rdy_i     (sat_rdy),
        .rx_data_i    (rx_data),
        .rx_k_i       (rx_k),
        .rx_enc_err_i (rx_enc_err),
        .rx_buf_err_i (rx_buf_err),
        .rx_synced_i  (sat_synced),
        .rx_resync_o  (sat_resync),
        .link_up_o    (sat_link),
        .data_o       (sat_data),
        .k_o          (sat_k),
        .valid_o      (sat_valid),
        .err_cnt_o    (sat_err_cnt),
        .resync_cnt_o (sat_resync_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, drain scoreboard.
    task automatic tick();
        logic [17:0] exp_word;
        @(posedge clk);
        #1;
        lpos++;
        if (valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                exp_word = sb_q.pop_front();
                check("sb_fwd_word", {14'd0, k_o, data_o}, {14'd0, exp_word});
            end
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic [1:0] k);
        rx_data = d;
        rx_k    = k;
    endtask

    task automatic wait_pos(input int p);
        do tick(); while ((lpos % 64) != p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        logic exp_v;

        rst_n = 1'b0; rx_rdy = 1'b0; rx_enc_err = 1'b0; rx_buf_err = 1'b0;
        rx_synced = 1'b0; sat_rdy = 1'b0; sat_synced = 1'b0;
        drive(IDLE, IDLE_K);

        // ---- 1: reset state, first resync pulse ----
        #3;
        check("rst_resync",     32'(rx_resync),  32'd0);
        check("rst_link",       32'(link_up),    32'd0);
        check("rst_valid",      32'(valid_o),    32'd0);
        check("rst_data",       32'(data_o),     32'd0);
        check("rst_k",          32'(k_o),        32'd0);
        check("rst_err_cnt",    32'(err_cnt),    32'd0);
        check("rst_resync_cnt", 32'(resync_cnt), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("wait_rdy_resync", 32'(rx_resync), 32'd0);
        rx_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_resync_pulse", 32'(rx_resync), 32'd1);
        end
        tick();
        check("t1_resync_end", 32'(rx_resync),  32'd0);
        check("t1_resync_cnt", 32'(resync_cnt), 32'd1);

        // ---- 2: acquisition, restart on a k=0 data word after 7 IDLEs ----
        rx_synced = 1'b1;
        tick();
        check("t2_acq_link", 32'(link_up), 32'd0);
        repeat (7) tick();
        drive(16'h1234, 2'b00);
        tick();
        drive(IDLE, IDLE_K);
        repeat (7) tick();
        check("t2_link_after_7", 32'(link_up), 32'd0);
        tick();
        check("t2_link_up", 32'(link_up), 32'd1);
        lpos = 0;

        // ---- 3: forwarding; table holds no error words ----
        for (int i = 0; i < 12; i++) begin
            drive(t3_data[i], t3_k[i]);
            exp_v = !(t3_data[i] == IDLE && t3_k[i] == IDLE_K);
            if (exp_v) sb_q.push_back({t3_k[i], t3_data[i]});
            tick();
            check("t3_valid", 32'(valid_o), 32'(exp_v));
        end
        drive(IDLE, IDLE_K);
        check("t3_sb_drained", 32'(sb_q.size()), 32'd0);

        // ---- 4a: 4 errors in one window (positions 12..15) force resync ----
        rx_enc_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4a_link_hold", 32'(link_up), 32'd1);
        end
        tick();
        rx_enc_err = 1'b0;
        check("t4a_link_drop",  32'(link_up),    32'd0);
        check("t4a_resync",     32'(rx_resync),  32'd1);
        check("t4a_resync_cnt", 32'(resync_cnt), 32'd2);
        check("t4a_err_cnt",    32'(err_cnt),    32'd4);
        check("t4a_valid",      32'(valid_o),    32'd0);

        // RESYNC 4 + WAIT_ALIGN 1 + ACQUIRE 8 cycles
        n = 0;
        while (link_up !== 1'b1 && n < 100) begin tick(); n++; end
        check("t4_relock_cycles", 32'(n), 32'd13);
        lpos = 0;

        // ---- 4b: 3 errors in one window, 1 in the next -> stays up ----
        wait_pos(10);
        rx_buf_err = 1'b1;
        repeat (3) tick();
        rx_buf_err = 1'b0;
        check("t4b_link_after_3", 32'(link_up), 32'd1);
        wait_pos(0);
        wait_pos(5);
        drive(IDLE, 2'b11);
        tick();
        drive(IDLE, IDLE_K);
        tick();
        check("t4b_link_hold",  32'(link_up),    32'd1);
        check("t4b_err_cnt",    32'(err_cnt),    32'd8);
        check("t4b_resync_cnt", 32'(resync_cnt), 32'd2);

        // ---- 6a: rx_rdy drop for one cycle while LOCKED ----
        drive(16'h1234, 2'b00);
        sb_q.push_back({2'b00, 16'h1234});
        tick();
        check("t6a_valid_before", 32'(valid_o), 32'd1);
        drive(16'h5678, 2'b00);
        rx_rdy = 1'b0;
        tick();
        check("t6a_link_drop",  32'(link_up),   32'd0);
        check("t6a_valid_drop", 32'(valid_o),   32'd0);
        check("t6a_resync_low", 32'(rx_resync), 32'd0);
        rx_rdy = 1'b1;
        rx_synced = 1'b0;
        drive(IDLE, IDLE_K);
        tick();
        check("t6a_restart_resync", 32'(rx_resync),  32'd1);
        check("t6a_resync_cnt",     32'(resync_cnt), 32'd3);
        check("t6a_err_cnt",        32'(err_cnt),    32'd8);

        // ---- 5: align timeout with rx_synced held low ----
        repeat (4) tick();
        check("t5_wait_align", 32'(rx_resync), 32'd0);
        n = 0;
        while (rx_resync !== 1'b1 && n < 2000) begin tick(); n++; end
        check("t5_timeout_cycles", 32'(n), 32'd1024);
        check("t5_resync_cnt_a", 32'(resync_cnt), 32'd4);
        w = 0;
        while (rx_resync === 1'b1 && w < 20) begin tick(); w++; end
        check("t5_pulse_width", 32'(w), 32'd4);
        n = 0;
        while (rx_resync !== 1'b1 && n < 2000) begin tick(); n++; end
        check("t5_timeout_cycles_b", 32'(n), 32'd1024);
        check("t5_resync_cnt_b", 32'(resync_cnt), 32'd5);

        // ---- 6b: asynchronous reset mid-LOCKED ----
        rx_synced = 1'b1;
        n = 0;
        while (link_up !== 1'b1 && n < 100) begin tick(); n++; end
        check("t6b_locked", 32'(link_up), 32'd1);
        drive(16'h4321, 2'b00);
        sb_q.push_back({2'b00, 16'h4321});
        tick();
        check("t6b_valid_before", 32'(valid_o), 32'd1);
        drive(IDLE, IDLE_K);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6b_async_link",       32'(link_up),    32'd0);
        check("t6b_async_valid",      32'(valid_o),    32'd0);
        check("t6b_async_data",       32'(data_o),     32'd0);
        check("t6b_async_k",          32'(k_o),        32'd0);
        check("t6b_async_resync",     32'(rx_resync),  32'd0);
        check("t6b_async_err_cnt",    32'(err_cnt),    32'd0);
        check("t6b_async_resync_cnt", 32'(resync_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6b_restart_resync", 32'(rx_resync),  32'd1);
        check("t6b_restart_cnt",    32'(resync_cnt), 32'd1);

        // ---- 5 (saturation) on the short-timing instance ----
        sat_rdy = 1'b1;
        tick();
        check("sat_first", 32'(sat_resync_cnt), 32'd1);
        n = 0;
        while (sat_resync_cnt !== 8'hFF && n < 2000) begin tick(); n++; end
        check("sat_reach_255", 32'(sat_resync_cnt), 32'd255);
        repeat (60) tick();
        check("sat_hold_255", 32'(sat_resync_cnt), 32'd255);

        check("sb_empty_end", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
